// File: rtl/icache_dm.sv
// icache_dm: direct-mapped read-only instruction cache with fixed-length burst line refill
module icache_dm #(
  parameter int INDEX_W  = 8,
  parameter int OFFSET_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic [31:0] addr,
  input  logic        inv,
  output logic        ready,
  output logic [31:0] inst,
  output logic        mem_rd_req,
  output logic [31:0] mem_rd_addr,
  input  logic        mem_rd_ready,
  input  logic        mem_rd_valid,
  input  logic [31:0] mem_rd_data,
  input  logic        mem_rd_last
);
  localparam int TAG_W  = 32 - INDEX_W - OFFSET_W;
  localparam int WORD_W = OFFSET_W - 2;
  localparam int BEATS  = 1 << WORD_W;
  localparam int LINES  = 1 << INDEX_W;

  typedef enum logic [1:0] {IDLE, REQ, REFILL, FILL} state_t;

  state_t              r_state;
  logic [LINES-1:0]    r_vld;
  logic [TAG_W-1:0]    r_tag  [LINES];
  logic [31:0]         r_data [LINES][BEATS];
  logic [31:0]         r_buf  [BEATS];
  logic [WORD_W-1:0]   r_cnt;
  logic                r_req;
  logic [31:0]         r_addr;
  logic                r_stale;

  logic [TAG_W-1:0]    w_tag;
  logic [INDEX_W-1:0]  w_idx;
  logic [INDEX_W-1:0]  w_fill_idx;
  logic [WORD_W-1:0]   w_word;
  logic                w_hit;
  logic                w_unused;

  assign w_tag       = addr[31-:TAG_W];
  assign w_idx       = addr[OFFSET_W+:INDEX_W];
  assign w_word      = addr[2+:WORD_W];
  assign w_fill_idx  = r_addr[OFFSET_W+:INDEX_W];
  assign w_hit       = r_vld[w_idx] && r_tag[w_idx] == w_tag;
  assign ready       = r_state == IDLE && valid && w_hit && !inv;
  assign inst        = ready ? r_data[w_idx][w_word] : '0;
  assign mem_rd_req  = r_req;
  assign mem_rd_addr = r_addr;
  // burst length is fixed by the beat counter, so the last marker carries no control meaning
  assign w_unused    = ^{mem_rd_last, addr[1:0]};

  // miss FSM, valid bits and stale tracking; an invalidate during a refill keeps the line from going valid
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_vld   <= '0;
      r_cnt   <= '0;
      r_req   <= 1'b0;
      r_addr  <= '0;
      r_stale <= 1'b0;
    end else begin
      case (r_state)
        IDLE:
          if (valid && !w_hit && !inv) begin
            r_addr  <= {addr[31:OFFSET_W], {OFFSET_W{1'b0}}};
            r_req   <= 1'b1;
            r_state <= REQ;
          end
        REQ:
          if (mem_rd_ready) begin
            r_req   <= 1'b0;
            r_cnt   <= '0;
            r_state <= REFILL;
          end
        REFILL:
          if (mem_rd_valid) begin
            r_cnt   <= r_cnt + 1'b1;
            r_state <= &r_cnt ? FILL : REFILL;
          end
        default:
          r_state <= IDLE;
      endcase
      r_stale <= r_state == FILL ? 1'b0 : r_stale || (inv && r_state != IDLE);
      if (inv)
        r_vld <= '0;
      else if (r_state == FILL && !r_stale)
        r_vld[w_fill_idx] <= 1'b1;
    end
  end

  // line buffer collects beats in order; FILL copies it with the tag into the captured index
  always_ff @(posedge clk) begin
    if (r_state == REFILL && mem_rd_valid)
      r_buf[r_cnt] <= mem_rd_data;
    if (r_state == FILL) begin
      r_tag[w_fill_idx] <= r_addr[31-:TAG_W];
      for (int i = 0; i < BEATS; i++)
        r_data[w_fill_idx][i] <= r_buf[i];
    end
  end
endmodule

// File: tb/tb_icache_dm.sv
// tb_icache_dm: scoreboard bench for icache_dm with a burst memory model
module tb_icache_dm;
  logic        clk = 0, rst = 1, valid = 0, inv = 0;
  logic [31:0] addr = 0;
  logic        ready, mem_rd_req;
  logic [31:0] inst, mem_rd_addr;
  logic        mem_rd_ready = 0, mem_rd_valid = 0, mem_rd_last = 0;
  logic [31:0] mem_rd_data = 0;

  int          n_chk = 0, n_fail = 0;
  logic [31:0] exp_inst[$];
  logic [31:0] exp_fill[$];
  int          rdy_delay = 0, gap_at = -1, gap_len = 0;

  always #5 clk = ~clk;

  icache_dm dut (
    .clk(clk), .rst(rst), .valid(valid), .addr(addr), .inv(inv),
    .ready(ready), .inst(inst),
    .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_ready(mem_rd_ready),
    .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data), .mem_rd_last(mem_rd_last)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] line, input int b);
    case (line)
      32'h1C000000: return 32'hA0 + 32'(b);
      32'h1C001000: return 32'hB0 + 32'(b);
      32'h1C002000: return 32'hC0 + 32'(b);
      32'h1C002010: return 32'hD0 + 32'(b);
      default:      return 32'hEE;
    endcase
  endfunction

  // monitor: every ready cycle consumes one expected instruction word
  always @(negedge clk) begin
    if (rst && ready) begin
      if (exp_inst.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL spurious_ready: inst 0x%08h with no fetch expected", inst);
      end else
        chk("inst", inst, exp_inst.pop_front());
    end
  end

  // memory model: checks each refill address, applies backpressure and beat gaps, then streams 4 beats
  initial begin
    logic [31:0] line;
    forever begin
      @(negedge clk);
      if (rst && mem_rd_req) begin
        line = mem_rd_addr;
        if (exp_fill.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL spurious_refill: addr 0x%08h", line);
        end else
          chk("refill_addr", line, exp_fill.pop_front());
        for (int i = 0; i < rdy_delay; i++) begin
          chk("req_held", {31'd0, mem_rd_req}, 32'd1);
          chk("addr_held", mem_rd_addr, line);
          @(negedge clk);
        end
        mem_rd_ready = 1;
        @(negedge clk);
        mem_rd_ready = 0;
        for (int b = 0; b < 4; b++) begin
          if (b == gap_at) begin
            mem_rd_valid = 0;
            repeat (gap_len) @(negedge clk);
          end
          mem_rd_valid = 1;
          mem_rd_data  = mem_word(line, b);
          mem_rd_last  = (b == 3);
          @(negedge clk);
        end
        mem_rd_valid = 0;
        mem_rd_last  = 0;
      end
    end
  end

  // present a fetch and hold it until ready; cyc counts cycles with the detect cycle as 1
  task automatic fetch(input logic [31:0] a, input logic [31:0] e, output int cyc);
    exp_inst.push_back(e);
    valid = 1;
    addr  = a;
    cyc   = 0;
    do begin
      cyc++;
      @(negedge clk);
    end while (!ready && cyc < 60);
    if (!ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL fetch_timeout: addr 0x%08h never ready", a);
      if (exp_inst.size() != 0) void'(exp_inst.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic hit(input logic [31:0] a, input logic [31:0] e);
    int c;
    fetch(a, e, c);
    chk("hit_latency", c, 1);
    chk("hit_no_req", {31'd0, mem_rd_req}, 32'd0);
  endtask

  initial begin
    int c;
    valid = 1;
    addr  = 32'h1C000004;
    #1 rst = 0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_ready", {31'd0, ready}, 32'd0);
      chk("rst_inst", inst, 32'd0);
      chk("rst_req", {31'd0, mem_rd_req}, 32'd0);
      chk("rst_addr", mem_rd_addr, 32'd0);
    end
    @(posedge clk);
    #1 rst = 1;

    exp_fill.push_back(32'h1C000000);
    fetch(32'h1C000004, 32'hA1, c);
    chk("cold_latency", c, 8);
    hit(32'h1C000000, 32'hA0);
    hit(32'h1C000008, 32'hA2);
    hit(32'h1C00000C, 32'hA3);

    exp_fill.push_back(32'h1C001000);
    fetch(32'h1C001000, 32'hB0, c);
    chk("conflict_latency", c, 8);
    exp_fill.push_back(32'h1C000000);
    fetch(32'h1C000000, 32'hA0, c);
    chk("conflict_refetch_latency", c, 8);

    rdy_delay = 5;
    gap_at    = 2;
    gap_len   = 2;
    exp_fill.push_back(32'h1C001000);
    fetch(32'h1C001008, 32'hB2, c);
    chk("backpressure_latency", c, 15);
    rdy_delay = 0;
    gap_at    = -1;
    gap_len   = 0;
    hit(32'h1C001000, 32'hB0);
    hit(32'h1C001004, 32'hB1);
    hit(32'h1C00100C, 32'hB3);

    exp_fill.push_back(32'h1C002010);
    fetch(32'h1C002010, 32'hD0, c);
    chk("second_index_latency", c, 8);

    exp_fill.push_back(32'h1C000000);
    exp_fill.push_back(32'h1C000000);
    fork
      fetch(32'h1C000008, 32'hA2, c);
      begin
        repeat (4) @(posedge clk);
        #1 inv = 1;
        @(posedge clk);
        #1 inv = 0;
      end
    join
    chk("stale_refill_latency", c, 15);
    exp_fill.push_back(32'h1C002010);
    fetch(32'h1C002010, 32'hD0, c);
    chk("resident_after_inv_latency", c, 8);

    addr = 32'h1C002010;
    inv  = 1;
    @(negedge clk);
    chk("inv_blocks_ready", {31'd0, ready}, 32'd0);
    @(posedge clk);
    #1 inv = 0;
    exp_fill.push_back(32'h1C002010);
    fetch(32'h1C002010, 32'hD0, c);
    chk("idle_inv_refetch_latency", c, 8);

    exp_fill.push_back(32'h1C000000);
    valid = 1;
    addr  = 32'h1C000000;
    repeat (3) @(posedge clk);
    #1;
    valid = 0;
    addr  = 32'h1C002000;
    repeat (4) @(posedge clk);
    #1;
    fetch(32'h1C000004, 32'hA1, c);
    chk("installed_after_drop", c, 1);
    exp_fill.push_back(32'h1C002000);
    fetch(32'h1C002000, 32'hC0, c);
    chk("redirect_latency", c, 8);
    valid = 0;

    repeat (20) @(posedge clk);
    #1;
    chk("inst_queue_drained", exp_inst.size(), 0);
    chk("fill_queue_drained", exp_fill.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
